clock_set_ctrl: RTL and testbench
=================================

CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line: DEB_CYCLES, 500000, consecutive stable cycles before a button level is accepted; BLINK_CYCLES, 12500000, cycles per blink half-period; TIMEOUT_CYCLES, 500000000, idle cycles before setting mode aborts.
REQ-002 Ports (name  direction  width  meaning), one per line:
  clk  in  1  system clock
  reset  in  1  asynchronous, active-low reset
  btn_mode  in  1  raw mode button, active-high, asynchronous
  btn_inc  in  1  raw increment button, active-high, asynchronous
  hour_in  in  5  current timekeeper hours, 0-23
  min_in  in  6  current timekeeper minutes, 0-59
  set_hour  out  5  hours value to load
  set_min  out  6  minutes value to load
  load  out  1  one-cycle pulse; timekeeper loads set_hour/set_min and clears seconds
  run_en  out  1  timekeeper count enable
  blank  out  4  per-digit blank mask for the display scanner; [3:2] hour tens/units, [1:0] minute tens/units
  mode  out  2  current FSM state

Function
REQ-003 Each button SHALL be synchronised through two flip-flops, then debounced: the accepted level changes only after the synchronised level differs from it for DEB_CYCLES consecutive cycles; any bounce restarts the count.
REQ-004 A press event SHALL be a one-cycle pulse on each 0->1 transition of the accepted level; release generates no event; a held button produces exactly one event.
REQ-005 FSM states SHALL be RUN=00, SET_H=01, SET_M=10, COMMIT=11; mode output equals the state.
REQ-006 RUN: run_en=1, blank=0000. A mode event SHALL capture hour_in/min_in into set_hour/set_min and move to SET_H on the same edge.
REQ-007 SET_H: run_en=0. An inc event SHALL increment set_hour, wrapping 23->0. A mode event SHALL move to SET_M.
REQ-008 SET_M: run_en=0. An inc event SHALL increment set_min, wrapping 59->0. A mode event SHALL move to COMMIT.
REQ-009 COMMIT SHALL last exactly one cycle with load=1 and run_en=0, then return to RUN; load SHALL be 0 in every other state.
REQ-010 A blink phase SHALL toggle every BLINK_CYCLES cycles. The phase SHALL be forced to visible, with its counter cleared, on entry to SET_H or SET_M and on every inc event.
REQ-011 blank SHALL be 1100 in SET_H and 0011 in SET_M while the phase is invisible; otherwise it SHALL be 0000.
REQ-012 In SET_H or SET_M, an idle counter SHALL clear on any mode or inc event. When it reaches TIMEOUT_CYCLES, the FSM SHALL return to RUN without a load pulse, and set_hour/set_min SHALL hold.
REQ-013 Mode and inc events in the same cycle: mode SHALL win and inc SHALL be discarded.
REQ-014 Inc events in RUN or COMMIT SHALL be ignored.
REQ-015 All outputs SHALL be registered; hour_in/min_in are sampled only on the RUN->SET_H edge.

Reset
REQ-016 Asserting reset low SHALL asynchronously force state=RUN, set_hour=0, set_min=0, load=0, run_en=1, blank=0000, all counters to 0, and accepted button levels to 0.
REQ-017 Reset asserted mid-setting SHALL abandon the edit with no load pulse, during or after reset.
REQ-018 After reset release, a button already held SHALL produce one event after DEB_CYCLES stable cycles.

Structure
REQ-019 A shared package SHALL hold the state encodings, HOUR_MAX=23, MIN_MAX=59, and the blank mask constants 1100/0011.
REQ-020 Debouncing (synchroniser, stability counter, edge pulse) SHALL be one sub-module, btn_debounce, instantiated twice; the counters are sized with $clog2 of their parameters.

Verification (DEB_CYCLES=4, BLINK_CYCLES=8, TIMEOUT_CYCLES=64)
REQ-021 Reset, hour_in=13, min_in=45, press mode -> SET_H, set_hour=13, set_min=45, run_en=0; then inc x11 -> set_hour=0 (wrap at 23).
REQ-022 In SET_M with set_min=58, inc x2 -> set_min=0; mode -> exactly one cycle of load=1 with set_hour/set_min stable, then RUN with run_en=1.
REQ-023 btn_inc bouncing 1-0-1-0 at 2-cycle intervals, then held 20 cycles -> exactly one increment, after DEB_CYCLES stable cycles.
REQ-024 In SET_H, no presses -> blank alternates 0000/1100 every 8 cycles; an inc mid-phase -> blank=0000 for the next 8 cycles; after 64 idle cycles -> RUN, load never asserted.
REQ-025 Mode and inc events in the same cycle in SET_H -> SET_M, set_hour unchanged; reset pulsed low in SET_M -> RUN, set_hour=0, set_min=0, load=0.

Source files
------------

// File: rtl/clock_set_ctrl_pkg.sv
// Shared encodings and limits for the clock-setting controller.
// Holds the FSM state codes, the wrap points for hours and minutes, and the display blank masks.
package clock_set_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_SET_H  = 2'b01,
        ST_SET_M  = 2'b10,
        ST_COMMIT = 2'b11
    } state_e;

    localparam logic [4:0] HOUR_MAX   = 5'd23;
    localparam logic [5:0] MIN_MAX    = 6'd59;

    localparam logic [3:0] BLANK_NONE = 4'b0000;
    localparam logic [3:0] BLANK_HOUR = 4'b1100;
    localparam logic [3:0] BLANK_MIN  = 4'b0011;

    // Out-of-range inputs fold back to zero instead of counting past the limit.
    function automatic logic [4:0] next_hour(input logic [4:0] h);
        return (h >= HOUR_MAX) ? 5'd0 : h + 5'd1;
    endfunction

    function automatic logic [5:0] next_min(input logic [5:0] m);
        return (m >= MIN_MAX) ? 6'd0 : m + 6'd1;
    endfunction

endpackage

// File: rtl/clock_set_ctrl_btn_debounce.sv
// Button conditioner: two-flop synchroniser, stability counter, and a press pulse
// on each accepted 0->1 transition of the level.
module btn_debounce
    import clock_set_ctrl_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int unsigned     CW     = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0]   CNT_TC = CW'(DEB_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    // Any cycle where the synchronised level agrees with the accepted one restarts the count.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_TC) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        press_d = level_d & ~level_q;
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// Clock-setting controller: lets the user edit hours then minutes with two buttons,
// blinks the field being edited, and loads the timekeeper on commit.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_RUN    | timekeeper counting, display fully visible
// ST_SET_H  | editing hours, hour digits blink
// ST_SET_M  | editing minutes, minute digits blink
// ST_COMMIT | single cycle, load pulse to the timekeeper
module clock_set_ctrl
    import clock_set_ctrl_pkg::*;
#(
    parameter int unsigned DEB_CYCLES     = 500000,
    parameter int unsigned BLINK_CYCLES   = 12500000,
    parameter int unsigned TIMEOUT_CYCLES = 500000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [4:0] hour_in,
    input  logic [5:0] min_in,
    output logic [4:0] set_hour,
    output logic [5:0] set_min,
    output logic       load,
    output logic       run_en,
    output logic [3:0] blank,
    output logic [1:0] mode
);

    localparam int unsigned   BW       = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam int unsigned   TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [BW-1:0] BLINK_TC = BW'(BLINK_CYCLES - 1);
    localparam logic [TW-1:0] IDLE_TC  = TW'(TIMEOUT_CYCLES - 1);

    logic mode_level, inc_level;
    logic mode_ev, inc_ev;

    state_e        state_q,    state_d;
    logic [4:0]    set_hour_q, set_hour_d;
    logic [5:0]    set_min_q,  set_min_d;
    logic          load_q,     load_d;
    logic          run_en_q,   run_en_d;
    logic [3:0]    blank_q,    blank_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          phase_q,    phase_d;
    logic [TW-1:0] idle_cnt_q, idle_cnt_d;
    logic          inc_taken;
    logic          blink_restart;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_mode),
        .level   (mode_level),
        .press   (mode_ev)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_inc),
        .level   (inc_level),
        .press   (inc_ev)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            set_hour_q  <= '0;
            set_min_q   <= '0;
            load_q      <= 1'b0;
            run_en_q    <= 1'b1;
            blank_q     <= BLANK_NONE;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            idle_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            set_hour_q  <= set_hour_d;
            set_min_q   <= set_min_d;
            load_q      <= load_d;
            run_en_q    <= run_en_d;
            blank_q     <= blank_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            idle_cnt_q  <= idle_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        set_hour_d = set_hour_q;
        set_min_d  = set_min_q;
        idle_cnt_d = '0;
        inc_taken  = 1'b0;

        // Mode is checked first everywhere, so a simultaneous inc is dropped.
        unique case (state_q)
            ST_RUN: begin
                if (mode_ev) begin
                    set_hour_d = hour_in;
                    set_min_d  = min_in;
                    state_d    = ST_SET_H;
                end
            end
            ST_SET_H: begin
                if (mode_ev) begin
                    state_d = ST_SET_M;
                end else if (inc_ev) begin
                    set_hour_d = next_hour(set_hour_q);
                    inc_taken  = 1'b1;
                end else if (idle_cnt_q == IDLE_TC) begin
                    state_d = ST_RUN;
                end else begin
                    idle_cnt_d = idle_cnt_q + TW'(1);
                end
            end
            ST_SET_M: begin
                if (mode_ev) begin
                    state_d = ST_COMMIT;
                end else if (inc_ev) begin
                    set_min_d = next_min(set_min_q);
                    inc_taken = 1'b1;
                end else if (idle_cnt_q == IDLE_TC) begin
                    state_d = ST_RUN;
                end else begin
                    idle_cnt_d = idle_cnt_q + TW'(1);
                end
            end
            ST_COMMIT: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        blink_restart = inc_taken ||
                        ((state_d != state_q) && ((state_d == ST_SET_H) || (state_d == ST_SET_M)));

        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (blink_restart) begin
            blink_cnt_d = '0;
            phase_d     = 1'b0;
        end else if (blink_cnt_q == BLINK_TC) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
        end

        // Outputs follow the next state so they stay aligned with the registered mode.
        load_d   = (state_d == ST_COMMIT);
        run_en_d = (state_d == ST_RUN);
        blank_d  = BLANK_NONE;
        if (phase_d && (state_d == ST_SET_H)) begin
            blank_d = BLANK_HOUR;
        end else if (phase_d && (state_d == ST_SET_M)) begin
            blank_d = BLANK_MIN;
        end
    end

    assign set_hour = set_hour_q;
    assign set_min  = set_min_q;
    assign load     = load_q;
    assign run_en   = run_en_q;
    assign blank    = blank_q;
    assign mode     = state_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with short debounce, blink and timeout periods.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_clock_set_ctrl;

    logic       clk;
    logic       reset;
    logic       btn_mode;
    logic       btn_inc;
    logic [4:0] hour_in;
    logic [5:0] min_in;
    logic [4:0] set_hour;
    logic [5:0] set_min;
    logic       load;
    logic       run_en;
    logic [3:0] blank;
    logic [1:0] mode;

    int n_checks  = 0;
    int n_pass    = 0;
    int load_seen = 0;

    clock_set_ctrl #(
        .DEB_CYCLES     (4),
        .BLINK_CYCLES   (8),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_mode (btn_mode),
        .btn_inc  (btn_inc),
        .hour_in  (hour_in),
        .min_in   (min_in),
        .set_hour (set_hour),
        .set_min  (set_min),
        .load     (load),
        .run_en   (run_en),
        .blank    (blank),
        .mode     (mode)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (load === 1'b1) load_seen++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // A held press is accepted on the 7th falling edge after the button rises.
    task automatic press_mode();
        btn_mode = 1'b1;
        cyc(10);
        btn_mode = 1'b0;
        cyc(10);
    endtask

    task automatic press_inc();
        btn_inc = 1'b1;
        cyc(10);
        btn_inc = 1'b0;
        cyc(10);
    endtask

    initial begin
        reset    = 1'b0;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        hour_in  = 5'd13;
        min_in   = 6'd45;
        cyc(3);
        check("rst_mode",   32'(mode),     0);
        check("rst_hour",   32'(set_hour), 0);
        check("rst_min",    32'(set_min),  0);
        check("rst_load",   32'(load),     0);
        check("rst_run_en", 32'(run_en),   1);
        check("rst_blank",  32'(blank),    0);
        reset = 1'b1;
        cyc(2);

        press_mode();
        check("enter_seth_mode", 32'(mode),     1);
        check("capture_hour",    32'(set_hour), 13);
        check("capture_min",     32'(set_min),  45);
        check("seth_run_en",     32'(run_en),   0);
        check("seth_load",       32'(load),     0);

        repeat (11) press_inc();
        check("hour_wrap",      32'(set_hour), 0);
        check("hour_wrap_mode", 32'(mode),     1);

        press_mode();
        check("enter_setm_mode", 32'(mode),     2);
        check("setm_hour_keep",  32'(set_hour), 0);

        repeat (13) press_inc();
        check("min_58", 32'(set_min), 58);
        repeat (2) press_inc();
        check("min_wrap", 32'(set_min), 0);

        btn_mode = 1'b1;
        cyc(6);
        check("pre_commit_load", 32'(load), 0);
        check("pre_commit_mode", 32'(mode), 2);
        cyc(1);
        check("commit_load",   32'(load),     1);
        check("commit_mode",   32'(mode),     3);
        check("commit_hour",   32'(set_hour), 0);
        check("commit_min",    32'(set_min),  0);
        check("commit_run_en", 32'(run_en),   0);
        cyc(1);
        check("post_commit_load",   32'(load),   0);
        check("post_commit_mode",   32'(mode),   0);
        check("post_commit_run_en", 32'(run_en), 1);
        btn_mode = 1'b0;
        cyc(12);

        press_inc();
        check("run_inc_ignored_hour", 32'(set_hour), 0);
        check("run_inc_ignored_mode", 32'(mode),     0);

        press_mode();
        check("reenter_hour", 32'(set_hour), 13);

        // Bounce 1-0-1-0 at 2-cycle intervals, then hold; k counts edges from the final rise.
        btn_inc = 1'b1; cyc(2);
        btn_inc = 1'b0; cyc(2);
        btn_inc = 1'b1; cyc(2);
        btn_inc = 1'b0; cyc(2);
        btn_inc = 1'b1;
        cyc(6);
        check("bounce_not_yet", 32'(set_hour), 13);
        cyc(1);                                             // k=7
        check("bounce_one_inc", 32'(set_hour), 14);
        check("blank_after_inc", 32'(blank), 0);
        cyc(7);                                             // k=14
        check("blank_vis_end", 32'(blank), 0);
        cyc(1);                                             // k=15
        check("blank_invis", 32'(blank), 12);
        cyc(5);                                             // k=20
        btn_inc = 1'b0;
        cyc(2);                                             // k=22
        check("blank_invis_end", 32'(blank), 12);
        check("held_no_extra_inc", 32'(set_hour), 14);
        cyc(1);                                             // k=23
        check("blank_vis_again", 32'(blank), 0);
        cyc(4);                                             // k=27
        btn_inc = 1'b1;
        cyc(6);                                             // k=33
        check("blank_pre_inc2", 32'(blank), 12);
        check("hour_pre_inc2", 32'(set_hour), 14);
        cyc(1);                                             // k=34
        check("hour_inc2", 32'(set_hour), 15);
        check("blank_inc2_forced", 32'(blank), 0);
        cyc(7);                                             // k=41
        check("blank_inc2_hold", 32'(blank), 0);
        cyc(1);                                             // k=42
        check("blank_inc2_toggle", 32'(blank), 12);
        check("still_seth", 32'(mode), 1);
        cyc(8);                                             // k=50
        btn_inc = 1'b0;
        cyc(47);                                            // k=97
        check("timeout_not_yet", 32'(mode), 1);
        cyc(1);                                             // k=98
        check("timeout_mode",   32'(mode),     0);
        check("timeout_run_en", 32'(run_en),   1);
        check("timeout_hour",   32'(set_hour), 15);
        check("timeout_nload",  32'(load_seen), 1);

        press_mode();
        check("tie_enter_hour", 32'(set_hour), 13);
        btn_mode = 1'b1;
        btn_inc  = 1'b1;
        cyc(10);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        cyc(10);
        check("tie_mode",      32'(mode),     2);
        check("tie_hour_keep", 32'(set_hour), 13);
        check("tie_min_keep",  32'(set_min),  45);

        reset = 1'b0;
        #1;
        check("midset_rst_mode",   32'(mode),     0);
        check("midset_rst_hour",   32'(set_hour), 0);
        check("midset_rst_min",    32'(set_min),  0);
        check("midset_rst_load",   32'(load),     0);
        check("midset_rst_run_en", 32'(run_en),   1);
        btn_mode = 1'b1;
        cyc(3);
        reset = 1'b1;
        cyc(6);
        check("held_after_rst_wait", 32'(mode), 0);
        cyc(1);
        check("held_after_rst_event", 32'(mode),     1);
        check("held_after_rst_hour",  32'(set_hour), 13);
        check("total_loads",          32'(load_seen), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
